// File: rtl/fifo_pkg.sv
// Shared widths and status bundle for the paced sync FIFO.
// Exports cnt_w/ptr_w helpers and fifo_status_t.
package fifo_pkg;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/fifo_slot_pacer.sv
// Issue-slot pacer: after TAKE, slot stays closed for P_IDLE cycles.
// Ports: CLK, RST_n, TAKE (transfer accepted), SLOT_OPEN (may transfer).
module fifo_slot_pacer #(
  parameter int P_IDLE = 1
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic TAKE,
  output logic SLOT_OPEN
);

  localparam int W = (P_IDLE > 0) ? $clog2(P_IDLE + 1) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      cnt <= '0;
    end else if (TAKE) begin
      cnt <= W'(P_IDLE);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign SLOT_OPEN = (cnt == '0);

endmodule

// File: rtl/paced_sync_fifo.sv
// Single-clock FIFO with paced ready/valid ports, status and error flags.
// Ports: DATA_IN/W_EN/W_RDY write side, R_EN/R_RDY/DATA_OUT/DATA_VALID read side.
module paced_sync_fifo
  import fifo_pkg::*;
#(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_MEM_DEPTH  = 333,
  parameter int P_WR_IDLE    = 2,
  parameter int P_RD_IDLE    = 1,
  parameter int P_AFULL      = 329,
  parameter int P_AEMPTY     = 4
) (
  input  logic                             CLK,
  input  logic                             RST_n,
  input  logic [P_DATA_WIDTH-1:0]          DATA_IN,
  input  logic                             W_EN,
  output logic                             W_RDY,
  input  logic                             R_EN,
  output logic                             R_RDY,
  output logic [P_DATA_WIDTH-1:0]          DATA_OUT,
  output logic                             DATA_VALID,
  output logic [$clog2(P_MEM_DEPTH+1)-1:0] COUNT,
  output logic                             FULL,
  output logic                             EMPTY,
  output logic                             ALMOST_FULL,
  output logic                             ALMOST_EMPTY,
  output logic                             OVERFLOW,
  output logic                             UNDERFLOW,
  input  logic                             CLR_ERR
);

  localparam int CW = cnt_w(P_MEM_DEPTH);
  localparam int PW = ptr_w(P_MEM_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(P_MEM_DEPTH - 1);

  if (P_MEM_DEPTH < 2) begin : g_bad_depth
    $error("P_MEM_DEPTH must be >= 2");
  end
  if (P_AFULL < 1 || P_AFULL > P_MEM_DEPTH) begin : g_bad_afull
    $error("P_AFULL out of range");
  end
  if (P_AEMPTY < 0 || P_AEMPTY > P_MEM_DEPTH - 1) begin : g_bad_aempty
    $error("P_AEMPTY out of range");
  end
  if (P_WR_IDLE < 0 || P_RD_IDLE < 0) begin : g_bad_idle
    $error("idle intervals must be >= 0");
  end

  logic [P_DATA_WIDTH-1:0] mem [P_MEM_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [CW-1:0]           count;
  fifo_status_t            st;
  logic                    w_open;
  logic                    r_open;
  logic                    wr;
  logic                    rd;
  logic                    ovf_set;
  logic                    unf_set;

  always_comb begin
    st.full         = (count == CW'(P_MEM_DEPTH));
    st.empty        = (count == '0);
    st.almost_full  = (count >= CW'(P_AFULL));
    st.almost_empty = (count <= CW'(P_AEMPTY));
  end

  assign W_RDY = w_open && !st.full;
  assign R_RDY = r_open && !st.empty;
  assign wr    = W_EN && W_RDY;
  assign rd    = R_EN && R_RDY;

  assign ovf_set = W_EN && st.full && w_open;
  assign unf_set = R_EN && st.empty && r_open;

  fifo_slot_pacer #(.P_IDLE(P_WR_IDLE)) u_wr_pacer (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .TAKE     (wr),
    .SLOT_OPEN(w_open)
  );

  fifo_slot_pacer #(.P_IDLE(P_RD_IDLE)) u_rd_pacer (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .TAKE     (rd),
    .SLOT_OPEN(r_open)
  );

  // Storage is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (wr) begin
      mem[wr_ptr] <= DATA_IN;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
      OVERFLOW   <= 1'b0;
      UNDERFLOW  <= 1'b0;
    end else begin
      DATA_VALID <= rd;
      if (wr) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (rd) begin
        DATA_OUT <= mem[rd_ptr];
        rd_ptr   <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      if (wr && !rd) begin
        count <= count + 1'b1;
      end else if (rd && !wr) begin
        count <= count - 1'b1;
      end
      // Set beats a same-cycle clear.
      OVERFLOW  <= ovf_set || (OVERFLOW && !CLR_ERR);
      UNDERFLOW <= unf_set || (UNDERFLOW && !CLR_ERR);
    end
  end

  assign COUNT        = count;
  assign FULL         = st.full;
  assign EMPTY        = st.empty;
  assign ALMOST_FULL  = st.almost_full;
  assign ALMOST_EMPTY = st.almost_empty;

endmodule

// File: tb/tb_paced_sync_fifo.sv
// Randomized bench for paced_sync_fifo against a queue/timestamp model.
// Small depth (5) to exercise fill, wrap, overflow and underflow.
module tb_paced_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int WI    = 2;
  localparam int RI    = 1;
  localparam int AF    = 4;
  localparam int AE    = 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic          w_en;
  logic          w_rdy;
  logic          r_en;
  logic          r_rdy;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;
  logic          clr_err;

  always #5 clk = ~clk;

  paced_sync_fifo #(
    .P_DATA_WIDTH(DW),
    .P_MEM_DEPTH (DEPTH),
    .P_WR_IDLE   (WI),
    .P_RD_IDLE   (RI),
    .P_AFULL     (AF),
    .P_AEMPTY    (AE)
  ) dut (
    .CLK         (clk),
    .RST_n       (rst_n),
    .DATA_IN     (data_in),
    .W_EN        (w_en),
    .W_RDY       (w_rdy),
    .R_EN        (r_en),
    .R_RDY       (r_rdy),
    .DATA_OUT    (data_out),
    .DATA_VALID  (data_valid),
    .COUNT       (count),
    .FULL        (full),
    .EMPTY       (empty),
    .ALMOST_FULL (almost_full),
    .ALMOST_EMPTY(almost_empty),
    .OVERFLOW    (overflow),
    .UNDERFLOW   (underflow),
    .CLR_ERR     (clr_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: contents as a queue, pacing as timestamps of last transfer.
  logic [DW-1:0] q[$];
  int            cyc;
  int            last_wr;
  int            last_rd;
  bit            m_ovf;
  bit            m_unf;
  bit            m_dv;
  logic [DW-1:0] m_dout;
  bit            pend;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cyc     = 0;
    last_wr = -100;
    last_rd = -100;
    m_ovf   = 0;
    m_unf   = 0;
    m_dv    = 0;
    m_dout  = '0;
    pend    = 0;
  endtask

  task automatic check_all();
    bit wo;
    bit ro;
    int n;
    n  = q.size();
    wo = (cyc - last_wr) > WI;
    ro = (cyc - last_rd) > RI;
    chk("w_rdy", 32'(w_rdy), 32'(wo && n < DEPTH));
    chk("r_rdy", 32'(r_rdy), 32'(ro && n > 0));
    chk("count", 32'(count), 32'(n));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("afull", 32'(almost_full), 32'(n >= AF));
    chk("aempty", 32'(almost_empty), 32'(n <= AE));
    chk("ovf", 32'(overflow), 32'(m_ovf));
    chk("unf", 32'(underflow), 32'(m_unf));
    chk("dvalid", 32'(data_valid), 32'(m_dv));
    chk("dout", 32'(data_out), 32'(m_dout));
  endtask

  // Called at a falling edge: check, drive, predict next rising edge.
  task automatic step(input bit we, input bit re, input bit clr);
    bit wo;
    bit ro;
    bit fl;
    bit em;
    bit wacc;
    bit racc;
    check_all();
    if (pend) begin
      we = 1;
    end else begin
      data_in = DW'($urandom);
    end
    w_en    = we;
    r_en    = re;
    clr_err = clr;
    wo   = (cyc - last_wr) > WI;
    ro   = (cyc - last_rd) > RI;
    fl   = q.size() == DEPTH;
    em   = q.size() == 0;
    wacc = we && wo && !fl;
    racc = re && ro && !em;
    m_ovf = (we && fl && wo) || (m_ovf && !clr);
    m_unf = (re && em && ro) || (m_unf && !clr);
    m_dv  = racc;
    if (racc) begin
      m_dout  = q.pop_front();
      last_rd = cyc;
    end
    if (wacc) begin
      q.push_back(data_in);
      last_wr = cyc;
    end
    pend = we && !wacc;
    cyc++;
    @(negedge clk);
  endtask

  task automatic burst(input int n, input int wp, input int rp,
                       input int cp);
    for (int i = 0; i < n; i++) begin
      step($urandom_range(99) < wp, $urandom_range(99) < rp,
           $urandom_range(99) < cp);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    w_en    = 1'b0;
    r_en    = 1'b0;
    clr_err = 1'b0;
    data_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state, then a held write burst to see the 1,0,0 W_RDY cadence.
    step(0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0);
    end
    // Full: overflow attempts, then clear.
    repeat (6) step(1, 0, 0);
    step(0, 0, 1);
    // Read and write both requested at FULL.
    step(1, 1, 0);
    step(0, 0, 0);
    // Drain, then underflow with a same-cycle write.
    repeat (20) step(0, 1, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    step(0, 0, 1);

    burst(300, 70, 30, 3);
    burst(300, 30, 70, 3);
    burst(600, 50, 50, 5);

    // Reset in mid-burst at COUNT=3.
    for (int i = 0; i < 40 && q.size() > 3; i++) step(0, 1, 0);
    for (int i = 0; i < 40 && q.size() < 3; i++) step(1, 0, 0);
    chk("pre_rst_count", 32'(count), 32'(3));
    w_en  = 1'b1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    w_en    = 1'b0;
    r_en    = 1'b0;
    clr_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    burst(400, 50, 50, 5);
    check_all();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1);
  end

endmodule

// File: doc/paced_sync_fifo.md
# paced_sync_fifo

Single-clock, parametrised FIFO buffer between a producer and a consumer that run at fixed, programmable issue rates. It generalises the team's producer/consumer FIFO: any depth (non-power-of-two included), any data width, independent write/read pacing intervals, and ready/valid handshakes. It also adds occupancy count, almost-full/almost-empty thresholds and sticky overflow/underflow flags. It sits between the producer datapath and the consumer datapath inside one clock domain.

## Interface
- P_DATA_WIDTH, 8, width of DATA_IN/DATA_OUT
- P_MEM_DEPTH, 333, number of entries; must be ≥2, need not be a power of two
- P_WR_IDLE, 2, idle cycles forced after each accepted write (0 = write every cycle)
- P_RD_IDLE, 1, idle cycles forced after each accepted read (0 = read every cycle)
- P_AFULL, 329, ALMOST_FULL threshold, legal range 1..P_MEM_DEPTH
- P_AEMPTY, 4, ALMOST_EMPTY threshold, legal range 0..P_MEM_DEPTH-1
- CLK  in  1  single clock, rising edge
- RST_n  in  1  asynchronous, active-low reset
- DATA_IN  in  P_DATA_WIDTH  write data
- W_EN  in  1  write request; producer holds it and DATA_IN stable until W_RDY is seen
- W_RDY  out  1  write slot open and not FULL
- R_EN  in  1  read request
- R_RDY  out  1  read slot open and not EMPTY
- DATA_OUT  out  P_DATA_WIDTH  registered read data
- DATA_VALID  out  1  one-cycle strobe qualifying DATA_OUT
- COUNT  out  $clog2(P_MEM_DEPTH+1)  current occupancy
- FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY  out  1 each  status
- OVERFLOW, UNDERFLOW  out  1 each  sticky error flags
- CLR_ERR  in  1  synchronous clear of both sticky flags

## Operation
- **Write transfer:** occurs at a rising edge when W_EN && W_RDY. DATA_IN is stored at wr_ptr, wr_ptr advances, and the write slot counter loads P_WR_IDLE.
- **Write slot counter:** decrements by 1 per cycle down to 0. The slot is open when the counter is 0.
- **Read transfer:** occurs when R_EN && R_RDY. DATA_OUT <= mem[rd_ptr], DATA_VALID is 1 for the next cycle, rd_ptr advances, and the read slot counter loads P_RD_IDLE.
- **DATA_OUT hold:** DATA_OUT holds its last value when no read occurs.
- **Pointer wrap:** pointers wrap by explicit compare (P_MEM_DEPTH-1 -> 0). No modulo operator is used.
- **Count update:** COUNT +1 on write only, -1 on read only, unchanged on a simultaneous read and write.
- **Status flags:** all decoded from registered COUNT.
  - FULL = COUNT==P_MEM_DEPTH
  - EMPTY = COUNT==0
  - ALMOST_FULL = COUNT≥P_AFULL
  - ALMOST_EMPTY = COUNT≤P_AEMPTY
- **Ready outputs:** W_RDY and R_RDY are combinational from the slot counters and FULL/EMPTY only. They never depend on W_EN/R_EN.
- **FULL with same-cycle read:** write is rejected even if a read occurs in the same cycle.
- **EMPTY with same-cycle write:** read is rejected even if a write occurs in the same cycle. There is no fall-through.
- **W_EN during an idle slot:** no transfer and not an error.
- **OVERFLOW:** set when W_EN && FULL && write slot open.
- **UNDERFLOW:** set when R_EN && EMPTY && read slot open.
- **Error flag clear:** both flags are cleared by CLR_ERR or reset. If set and clear occur in the same cycle, set wins.
- **Rejected requests:** never change memory, pointers or COUNT.
- **Memory on reset:** memory contents are not reset; only control state is reset.

## Timing
- **Reset values (asynchronous, take effect immediately on RST_n=0):**
  - wr_ptr=rd_ptr=0, COUNT=0, slot counters=0
  - DATA_OUT=0, DATA_VALID=0
  - FULL=0, EMPTY=1, ALMOST_FULL=0, ALMOST_EMPTY=1
  - OVERFLOW=UNDERFLOW=0
  - W_RDY=1, R_RDY=0
- **Reset mid-operation:** all in-flight data is discarded; the FIFO reads as empty on the first edge after release.
- **Write-to-read latency:** data written at edge k makes EMPTY=0 after edge k. Its earliest read is at edge k+1, with DATA_VALID high during the cycle after edge k+1.
- **Read latency:** 1 cycle from the accepting edge to DATA_OUT/DATA_VALID.
- **Write pacing:** with P_WR_IDLE=N, accepted writes are at least N+1 cycles apart.
- **Read pacing:** with P_RD_IDLE=M, accepted reads are at least M+1 cycles apart.
- **Status update:** status outputs update in the same cycle as COUNT, one edge after the transfer.

## Structure
- **Package fifo_pkg:** holds the count/pointer width functions (clog2 of depth and of depth+1) and the shared status struct (full, empty, almost_full, almost_empty).
- **Parameter checks:** elaboration-time assertions on the legal parameter ranges.
- **Sub-module fifo_slot_pacer:** parameter P_IDLE, ports CLK, RST_n, TAKE, SLOT_OPEN. It is instantiated twice, once for write pacing and once for read pacing.
- **Top level:** memory array, pointers, COUNT and flag logic live in paced_sync_fifo.

## Test plan
- **Reset check:** assert RST_n=0 mid-burst with COUNT=3 -> all outputs at their reset values immediately; a read after release gives R_RDY=0 and UNDERFLOW stays 0 until R_EN is asserted.
- **Write pacing:** P_WR_IDLE=2, W_EN held high with data 0x01,0x02,... -> writes accepted every 3rd cycle; W_RDY pattern 1,0,0,1,0,0.
- **Fill, overflow and clear (P_MEM_DEPTH=5, P_AFULL=4):**
  - write 5 entries -> FULL=1, ALMOST_FULL=1 from the 4th write.
  - 6th write attempt -> OVERFLOW=1, COUNT stays 5.
  - CLR_ERR -> OVERFLOW=0.
- **Wrap-around (depth 5, non-power-of-two):** write 0xA0..0xA6 interleaved with reads -> DATA_OUT sequence 0xA0..0xA6 in order across pointer wrap 4->0.
- **Simultaneous read/write:** at COUNT=2, same-cycle accepted read and write -> COUNT stays 2; at FULL with both requested -> read only, COUNT 5->4.
- **Underflow:** R_EN on an empty FIFO with the read slot open -> UNDERFLOW=1, DATA_VALID=0, DATA_OUT unchanged; a write in the same cycle does not satisfy the read.
